// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
package hazard_pkg;

   localparam int SEL_NONE = 0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   function automatic int fwd_sel_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one E-stage source register against all forwarding stages.
module fwd_match
   import hazard_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = 5,
   parameter int SEL_W   = 2,
   parameter bit GUARD   = 1'b1
) (
   input  logic [REG_AW-1:0]         src,
   input  logic [NUM_FWD-1:0]        fwd_wen,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
   output logic [SEL_W-1:0]          sel
);

   // Scan oldest to youngest so the youngest matching stage overwrites last.
   always_comb begin
      sel = SEL_W'(SEL_NONE);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_wen[k] && (fwd_addr[k*REG_AW +: REG_AW] == src)) begin
            sel = SEL_W'(k + 1);
         end
      end
      if (GUARD && (src == '0)) begin
         sel = SEL_W'(SEL_NONE);
      end
   end

endmodule

// File: rtl/hazard_ctrl_gen.sv
// Hazard and forwarding controller: operand forwarding, stall sequencing,
// deferred flushes and a saturating stall-cycle counter.
module hazard_ctrl_gen
   import hazard_pkg::*;
#(
   parameter int                 NUM_SRC    = 2,
   parameter int                 NUM_FWD    = 2,
   parameter int                 REG_AW     = 5,
   parameter logic [NUM_SRC-1:0] ZERO_GUARD = '1,
   parameter int                 CNT_W      = 32,
   localparam int                SEL_W      = fwd_sel_w(NUM_FWD)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_cache_stall,
   input  logic                        i_cache_hit,
   input  logic                        d_cache_stall,
   input  logic                        div_stallE,
   input  logic                        flush_jump_conflictE,
   input  logic                        flush_pred_failedM,
   input  logic                        flush_exceptionM,
   input  logic [NUM_SRC*REG_AW-1:0]   src_regE,
   input  logic [NUM_FWD-1:0]          fwd_wen,
   input  logic [NUM_FWD*REG_AW-1:0]   fwd_addr,
   input  logic                        perf_clr,
   output logic [NUM_SRC*SEL_W-1:0]    forward_sel,
   output logic                        stallF,
   output logic                        stallD,
   output logic                        stallE,
   output logic                        stallM,
   output logic                        stallW,
   output logic                        flushF,
   output logic                        flushD,
   output logic                        flushE,
   output logic                        flushM,
   output logic                        flushW,
   output logic                        en_stall,
   output logic                        flush_pending,
   output logic [CNT_W-1:0]            stall_cycles
);

   state_t             st;
   state_t             st_nxt;
   logic               ls;
   logic               en_stall_raw;
   logic               release_win;
   logic               pipe_stall;
   logic               pend_pred;
   logic               pend_jump;
   logic               pend_clr;
   logic               pf;
   logic               jf;
   logic               active;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_SRC*SEL_W-1:0] sel_raw;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_match #(
         .NUM_FWD (NUM_FWD),
         .REG_AW  (REG_AW),
         .SEL_W   (SEL_W),
         .GUARD   (ZERO_GUARD[i])
      ) u_match (
         .src      (src_regE[i*REG_AW +: REG_AW]),
         .fwd_wen  (fwd_wen),
         .fwd_addr (fwd_addr),
         .sel      (sel_raw[i*SEL_W +: SEL_W])
      );
   end

   assign ls     = i_cache_stall | d_cache_stall | div_stallE;
   assign active = ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= ST_RUN;
      end else begin
         st <= st_nxt;
      end
   end

   // The cycle after a long stall ends always advances, even without a fetch hit.
   always_comb begin
      st_nxt       = ls ? ST_STALL : ST_RUN;
      en_stall_raw = ls | (st == ST_STALL);
      release_win  = (st == ST_STALL) & ~ls;
      pipe_stall   = ~release_win & ~i_cache_hit;
   end

   // Flushes that arrive while stalled are held until the pipe moves.
   assign pend_clr = ~pipe_stall | flush_exceptionM;

   always_ff @(posedge clk) begin
      if (rst || pend_clr) begin
         pend_pred <= 1'b0;
         pend_jump <= 1'b0;
      end else begin
         if (flush_pred_failedM)   pend_pred <= 1'b1;
         if (flush_jump_conflictE) pend_jump <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         cnt <= '0;
      end else if (pipe_stall && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign pf = flush_pred_failedM | pend_pred;
   assign jf = flush_jump_conflictE | pend_jump;

   assign forward_sel   = active ? sel_raw : '0;
   assign stall_cycles  = active ? cnt : '0;
   assign en_stall      = active & en_stall_raw;
   assign flush_pending = active & (pend_pred | pend_jump);

   assign stallF = active & pipe_stall & ~flush_exceptionM;
   assign stallD = active & pipe_stall;
   assign stallE = active & pipe_stall;
   assign stallM = active & pipe_stall;
   assign stallW = active & pipe_stall;

   assign flushF = 1'b0;
   assign flushW = 1'b0;
   assign flushD = active & (flush_exceptionM | ((pf | jf) & ~pipe_stall));
   assign flushE = active & (flush_exceptionM | (pf & ~div_stallE & ~pipe_stall));
   assign flushM = active & (flush_exceptionM | (div_stallE & ~pipe_stall));

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Directed bench for hazard_ctrl_gen (counter narrowed to 4 bits to reach saturation).
module tb_hazard_ctrl_gen;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_cache_stall, i_cache_hit, d_cache_stall, div_stallE;
   logic          flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
   logic [9:0]    src_regE;
   logic [1:0]    fwd_wen;
   logic [9:0]    fwd_addr;
   logic          perf_clr;
   logic [3:0]    forward_sel;
   logic          stallF, stallD, stallE, stallM, stallW;
   logic          flushF, flushD, flushE, flushM, flushW;
   logic          en_stall, flush_pending;
   logic [CW-1:0] stall_cycles;
   logic [11:0]   obs;

   int vectors    = 0;
   int miscompares = 0;

   hazard_ctrl_gen #(.CNT_W(CW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .i_cache_stall        (i_cache_stall),
      .i_cache_hit          (i_cache_hit),
      .d_cache_stall        (d_cache_stall),
      .div_stallE           (div_stallE),
      .flush_jump_conflictE (flush_jump_conflictE),
      .flush_pred_failedM   (flush_pred_failedM),
      .flush_exceptionM     (flush_exceptionM),
      .src_regE             (src_regE),
      .fwd_wen              (fwd_wen),
      .fwd_addr             (fwd_addr),
      .perf_clr             (perf_clr),
      .forward_sel          (forward_sel),
      .stallF               (stallF),
      .stallD               (stallD),
      .stallE               (stallE),
      .stallM               (stallM),
      .stallW               (stallW),
      .flushF               (flushF),
      .flushD               (flushD),
      .flushE               (flushE),
      .flushM               (flushM),
      .flushW               (flushW),
      .en_stall             (en_stall),
      .flush_pending        (flush_pending),
      .stall_cycles         (stall_cycles)
   );

   always #5 clk = ~clk;

   // {stallF,D,E,M,W}_{flushF,D,E,M,W}_{en_stall,flush_pending}
   assign obs = {stallF, stallD, stallE, stallM, stallW,
                 flushF, flushD, flushE, flushM, flushW,
                 en_stall, flush_pending};

   task automatic idle();
      i_cache_stall = 0; i_cache_hit = 1; d_cache_stall = 0; div_stallE = 0;
      flush_jump_conflictE = 0; flush_pred_failedM = 0; flush_exceptionM = 0;
      perf_clr = 0;
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1; d_cache_stall = 1; i_cache_hit = 0; flush_exceptionM = 1;
      flush_pred_failedM = 1; src_regE = {5'd5, 5'd5}; fwd_wen = 2'b11;
      fwd_addr = {5'd5, 5'd5};
      cyc(); cyc(); #2;
      vectors++;
      if (obs !== 12'b00000_00000_00) begin
         miscompares++; $display("FAIL reset_ctrl got=%b exp=%b", obs, 12'b0);
      end
      vectors++;
      if (forward_sel !== 4'b0000) begin
         miscompares++; $display("FAIL reset_fsel got=%b exp=0000", forward_sel);
      end
      vectors++;
      if (stall_cycles !== 4'd0) begin
         miscompares++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles);
      end
      cyc();
      rst = 0; idle(); fwd_wen = 2'b00;
      cyc();
   endtask

   task automatic test_forward();
      src_regE = {5'd5, 5'd5}; fwd_wen = 2'b11; fwd_addr = {5'd5, 5'd5}; #2;
      vectors++;
      if (forward_sel !== 4'b0101) begin
         miscompares++; $display("FAIL fwd_m_prio got=%b exp=0101", forward_sel);
      end
      fwd_wen = 2'b10; #2;
      vectors++;
      if (forward_sel !== 4'b1010) begin
         miscompares++; $display("FAIL fwd_w_only got=%b exp=1010", forward_sel);
      end
      src_regE = {5'd7, 5'd5}; fwd_wen = 2'b11; fwd_addr = {5'd7, 5'd5}; #2;
      vectors++;
      if (forward_sel !== 4'b1001) begin
         miscompares++; $display("FAIL fwd_split got=%b exp=1001", forward_sel);
      end
      src_regE = {5'd9, 5'd4}; #2;
      vectors++;
      if (forward_sel !== 4'b0000) begin
         miscompares++; $display("FAIL fwd_nomatch got=%b exp=0000", forward_sel);
      end
   endtask

   task automatic test_zero_guard();
      src_regE = {5'd9, 5'd0}; fwd_wen = 2'b01; fwd_addr = {5'd9, 5'd0}; #2;
      vectors++;
      if (forward_sel !== 4'b0000) begin
         miscompares++; $display("FAIL zero_guard_rs got=%b exp=0000", forward_sel);
      end
      src_regE = {5'd3, 5'd0}; fwd_wen = 2'b11; fwd_addr = {5'd3, 5'd0}; #2;
      vectors++;
      if (forward_sel !== 4'b1000) begin
         miscompares++; $display("FAIL zero_guard_mix got=%b exp=1000", forward_sel);
      end
      fwd_wen = 2'b00;
   endtask

   task automatic test_stall_release();
      idle(); perf_clr = 1;
      cyc();
      idle(); d_cache_stall = 1; i_cache_hit = 0;
      for (int c = 1; c <= 3; c++) begin
         #2;
         vectors++;
         if (obs !== 12'b11111_00000_10) begin
            miscompares++; $display("FAIL stall_c%0d got=%b exp=%b", c, obs, 12'b11111_00000_10);
         end
         cyc();
      end
      d_cache_stall = 0; #2;
      vectors++;
      if (obs !== 12'b00000_00000_10) begin
         miscompares++; $display("FAIL release got=%b exp=%b", obs, 12'b00000_00000_10);
      end
      vectors++;
      if (stall_cycles !== 4'd3) begin
         miscompares++; $display("FAIL stall_count got=%0d exp=3", stall_cycles);
      end
      cyc();
      idle(); #2;
      vectors++;
      if (obs !== 12'b00000_00000_00) begin
         miscompares++; $display("FAIL after_release got=%b exp=%b", obs, 12'b0);
      end
      cyc();
   endtask

   task automatic test_deferred_flush();
      idle(); i_cache_stall = 1; i_cache_hit = 0; flush_pred_failedM = 1; #2;
      vectors++;
      if (obs !== 12'b11111_00000_10) begin
         miscompares++; $display("FAIL defer_req got=%b exp=%b", obs, 12'b11111_00000_10);
      end
      cyc();
      flush_pred_failedM = 0; #2;
      vectors++;
      if (obs !== 12'b11111_00000_11) begin
         miscompares++; $display("FAIL defer_hold got=%b exp=%b", obs, 12'b11111_00000_11);
      end
      cyc();
      i_cache_stall = 0; #2;
      vectors++;
      if (obs !== 12'b00000_01100_11) begin
         miscompares++; $display("FAIL defer_apply got=%b exp=%b", obs, 12'b00000_01100_11);
      end
      cyc();
      idle(); #2;
      vectors++;
      if (obs !== 12'b00000_00000_00) begin
         miscompares++; $display("FAIL defer_clear got=%b exp=%b", obs, 12'b0);
      end
      cyc();
   endtask

   task automatic test_exception();
      idle(); d_cache_stall = 1; i_cache_hit = 0; flush_jump_conflictE = 1;
      cyc();
      flush_jump_conflictE = 0; flush_exceptionM = 1; #2;
      vectors++;
      if (obs !== 12'b01111_01110_11) begin
         miscompares++; $display("FAIL exc_flush got=%b exp=%b", obs, 12'b01111_01110_11);
      end
      cyc();
      flush_exceptionM = 0; #2;
      vectors++;
      if (obs !== 12'b11111_00000_10) begin
         miscompares++; $display("FAIL exc_pend_clr got=%b exp=%b", obs, 12'b11111_00000_10);
      end
      cyc();
      d_cache_stall = 0; #2;
      vectors++;
      if (obs !== 12'b00000_00000_10) begin
         miscompares++; $display("FAIL exc_release got=%b exp=%b", obs, 12'b00000_00000_10);
      end
      cyc();
      idle();
      cyc();
   endtask

   task automatic test_div_flush();
      idle(); div_stallE = 1; flush_pred_failedM = 1; #2;
      vectors++;
      if (obs !== 12'b00000_01010_10) begin
         miscompares++; $display("FAIL div_flush got=%b exp=%b", obs, 12'b00000_01010_10);
      end
      cyc();
      idle(); #2;
      vectors++;
      if (obs !== 12'b00000_00000_10) begin
         miscompares++; $display("FAIL div_release got=%b exp=%b", obs, 12'b00000_00000_10);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      idle(); d_cache_stall = 1; i_cache_hit = 0; flush_jump_conflictE = 1;
      cyc();
      d_cache_stall = 0; #2;
      vectors++;
      if (obs !== 12'b00000_01000_11) begin
         miscompares++; $display("FAIL b2b_jump got=%b exp=%b", obs, 12'b00000_01000_11);
      end
      cyc();
      idle(); #2;
      vectors++;
      if (obs !== 12'b00000_00000_00) begin
         miscompares++; $display("FAIL b2b_single got=%b exp=%b", obs, 12'b0);
      end
      cyc();
   endtask

   task automatic test_reset_mid_stall();
      idle(); d_cache_stall = 1; i_cache_hit = 0; flush_pred_failedM = 1;
      cyc();
      flush_pred_failedM = 0; #2;
      vectors++;
      if (obs !== 12'b11111_00000_11) begin
         miscompares++; $display("FAIL rstmid_pend got=%b exp=%b", obs, 12'b11111_00000_11);
      end
      cyc();
      rst = 1; #2;
      vectors++;
      if ({obs, stall_cycles} !== 16'h0000) begin
         miscompares++; $display("FAIL rstmid_out got=%b cnt=%0d exp=0", obs, stall_cycles);
      end
      cyc();
      rst = 0; idle(); #2;
      vectors++;
      if (obs !== 12'b00000_00000_00) begin
         miscompares++; $display("FAIL rstmid_run got=%b exp=%b", obs, 12'b0);
      end
      vectors++;
      if (stall_cycles !== 4'd0) begin
         miscompares++; $display("FAIL rstmid_cnt got=%0d exp=0", stall_cycles);
      end
      cyc();
   endtask

   task automatic test_saturation();
      idle(); perf_clr = 1;
      cyc();
      idle(); d_cache_stall = 1; i_cache_hit = 0;
      for (int c = 0; c < 17; c++) cyc();
      perf_clr = 1; #2;
      vectors++;
      if (stall_cycles !== 4'd15) begin
         miscompares++; $display("FAIL cnt_saturate got=%0d exp=15", stall_cycles);
      end
      cyc();
      perf_clr = 0; d_cache_stall = 0; #2;
      vectors++;
      if (stall_cycles !== 4'd0) begin
         miscompares++; $display("FAIL cnt_clr_prio got=%0d exp=0", stall_cycles);
      end
      cyc();
      idle();
      cyc();
   endtask

   initial begin
      src_regE = '0; fwd_wen = '0; fwd_addr = '0;
      test_reset();
      test_forward();
      test_zero_guard();
      test_stall_release();
      test_deferred_flush();
      test_exception();
      test_div_flush();
      test_back_to_back();
      test_reset_mid_stall();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
